// File: rtl/led_pkg.sv
// Register map, CTRL bit positions and reset values shared by the LED PWM driver files.
package led_pkg;

  localparam logic [7:0] DUTY_OFFSET  = 8'd0;
  localparam logic [7:0] CTRL_OFFSET  = 8'd1;

  localparam int         EN_BIT       = 7;
  localparam int         BLINK_EN_BIT = 0;
  localparam int         RATE_LSB     = 1;

  localparam logic [7:0] CTRL_RESET   = 8'h80;
  localparam logic [7:0] DUTY_RESET   = 8'hFF;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DUTY,
    REG_CTRL
  } reg_sel_e;

  function automatic reg_sel_e reg_decode(input logic [7:0] addr, input logic [7:0] base);
    if (addr == 8'(base + DUTY_OFFSET)) return REG_DUTY;
    if (addr == 8'(base + CTRL_OFFSET)) return REG_CTRL;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// PWM core: prescaler tick, 8-bit period counter and a duty shadow reloaded only at period
// start, so a duty change never truncates the pulse in flight.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PwmDivBits = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] duty,
  output logic       pwm_on
);

  logic       tick;
  logic [7:0] pwm_cnt;
  logic [7:0] duty_active;

  generate
    if (PwmDivBits == 0) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      logic [PwmDivBits-1:0] prescaler;

      always_ff @(posedge CLK) begin
        if (!RESET) begin
          prescaler <= '0;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end

      assign tick = &prescaler;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pwm_cnt     <= 8'h00;
      duty_active <= DUTY_RESET;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
      // Shadow reload on the FF->00 wrap; a same-edge DUTY write lands next period.
      if (pwm_cnt == 8'hFF) begin
        duty_active <= duty;
      end
    end
  end

  assign pwm_on = (duty_active == 8'hFF) | (pwm_cnt < duty_active);

endmodule

// File: rtl/led_pwm_driver.sv
// LED brightness/blink stage with DUTY at BaseAddr and CTRL at BaseAddr+1 on the shared bus.
// Define LED_PWM_READBACK_EN to make both registers readable; otherwise the block is write-only.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter logic [7:0] BaseAddr   = 8'hC2,
  parameter int         PwmDivBits = 8,
  parameter int         BlinkBits  = 25
) (
  input  logic        CLK,
  input  logic        RESET,
  inout  wire  [7:0]  BUS_DATA,
  input  logic [7:0]  BUS_ADDR,
  input  logic        BUS_WE,
  input  logic [15:0] LED_IN,
  output logic [15:0] LED_OUT
);

  reg_sel_e             sel;
  logic [7:0]           duty_q;
  logic                 ctrl_en;
  logic                 ctrl_blink;
  logic [1:0]           ctrl_rate;
  logic [BlinkBits-1:0] blink_cnt;
  logic                 blink_bit;
  logic                 blink_on;
  logic                 pwm_on;

  assign sel = reg_decode(BUS_ADDR, BaseAddr);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      duty_q     <= DUTY_RESET;
      ctrl_en    <= CTRL_RESET[EN_BIT];
      ctrl_blink <= CTRL_RESET[BLINK_EN_BIT];
      ctrl_rate  <= CTRL_RESET[RATE_LSB +: 2];
    end else if (BUS_WE) begin
      if (sel == REG_DUTY) begin
        duty_q <= BUS_DATA;
      end
      if (sel == REG_CTRL) begin
        ctrl_en    <= BUS_DATA[EN_BIT];
        ctrl_blink <= BUS_DATA[BLINK_EN_BIT];
        ctrl_rate  <= BUS_DATA[RATE_LSB +: 2];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Each rate step taps one bit lower, doubling the blink frequency.
  always_comb begin
    blink_bit = blink_cnt[BlinkBits-1];
    case (ctrl_rate)
      2'd0:    blink_bit = blink_cnt[BlinkBits-1];
      2'd1:    blink_bit = blink_cnt[BlinkBits-2];
      2'd2:    blink_bit = blink_cnt[BlinkBits-3];
      default: blink_bit = blink_cnt[BlinkBits-4];
    endcase
  end

  assign blink_on = ~ctrl_blink | blink_bit;

  led_pwm_gen #(
    .PwmDivBits(PwmDivBits)
  ) u_pwm_gen (
    .CLK   (CLK),
    .RESET (RESET),
    .duty  (duty_q),
    .pwm_on(pwm_on)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      LED_OUT <= 16'h0000;
    end else begin
      LED_OUT <= LED_IN & {16{ctrl_en & pwm_on & blink_on}};
    end
  end

`ifdef LED_PWM_READBACK_EN
  logic [7:0] data_out;
  logic       drive_en;
  logic [7:0] ctrl_rd;

  assign ctrl_rd = {ctrl_en, 4'b0000, ctrl_rate, ctrl_blink};

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      data_out <= 8'h00;
      drive_en <= 1'b0;
    end else begin
      data_out <= (sel == REG_CTRL) ? ctrl_rd : duty_q;
      drive_en <= (sel != REG_NONE) && !BUS_WE;
    end
  end

  // BUS_WE gates the driver directly so a write cycle never sees contention.
  assign BUS_DATA = (drive_en && !BUS_WE) ? data_out : 8'hzz;
`else
  assign BUS_DATA = 8'hzz;
`endif

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with PwmDivBits=0 and BlinkBits=6; an undriven bus
// reads as 8'hFF through the tri1 net.
module tb_led_pwm_driver;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  bus_addr = 8'h00;
  logic        bus_we = 1'b0;
  logic [15:0] led_in = 16'h0000;
  wire  [15:0] led_out;
  tri1  [7:0]  bus_data;
  logic [7:0]  tb_dat = 8'h00;
  logic        tb_drv = 1'b0;

  int total = 0;
  int bad = 0;
  logic hist [1024];
  logic [7:0] rd_ctrl_ff;
  logic [7:0] rd_ctrl_81;
  int h;
  int t;

  assign bus_data = tb_drv ? tb_dat : 8'hzz;

  led_pwm_driver #(
    .BaseAddr  (8'hC2),
    .PwmDivBits(0),
    .BlinkBits (6)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BUS_DATA(bus_data),
    .BUS_ADDR(bus_addr),
    .BUS_WE  (bus_we),
    .LED_IN  (led_in),
    .LED_OUT (led_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_addr = a;
    bus_we   = 1'b1;
    tb_dat   = d;
    tb_drv   = 1'b1;
    @(negedge CLK);
    bus_we   = 1'b0;
    tb_drv   = 1'b0;
    bus_addr = 8'h00;
  endtask

  task automatic collect(input int n, output int highs, output int trans);
    logic prev;
    logic cur;
    highs = 0;
    trans = 0;
    prev  = (led_out != 16'h0000);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cur = (led_out != 16'h0000);
      if (cur) highs++;
      if (cur != prev) trans++;
      prev = cur;
    end
  endtask

  task automatic wait_rise(input string tag);
    logic prev;
    logic seen;
    prev = (led_out != 16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge CLK);
      if ((led_out != 16'h0000) && !prev) seen = 1'b1;
      prev = (led_out != 16'h0000);
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  function automatic int ones(input int lo, input int n);
    int c;
    c = 0;
    for (int i = lo; i < lo + n; i++) if (hist[i]) c++;
    return c;
  endfunction

  initial begin
`ifdef LED_PWM_READBACK_EN
    rd_ctrl_ff = 8'h87;
    rd_ctrl_81 = 8'h81;
`else
    rd_ctrl_ff = 8'hFF;
    rd_ctrl_81 = 8'hFF;
`endif

    // Reset with LED word held, then release.
    led_in = 16'hA5A5;
    cyc(3);
    check("rst_led", led_out, 16'h0000);
    check("rst_bus", bus_data, 8'hFF);
    RESET = 1'b1;
    check("rel_led_same", led_out, 16'h0000);
    @(negedge CLK);
    check("rel_led_next", led_out, 16'hA5A5);

    // DUTY=40: 64 of 256 cycles on, one contiguous pulse.
    wr(8'hC2, 8'h40);
    cyc(520);
    collect(256, h, t);
    check("duty40_high", h, 64);
    check("duty40_trans", t, 2);

    // Mid-period write (08) then a write on the wrap edge (C0).
    wait_rise("sync_rise");
    hist[0] = (led_out != 16'h0000);
    for (int i = 1; i < 1024; i++) begin
      if (i - 1 == 10) begin
        bus_addr = 8'hC2; bus_we = 1'b1; tb_dat = 8'h08; tb_drv = 1'b1;
      end else if (i - 1 == 510) begin
        bus_addr = 8'hC2; bus_we = 1'b1; tb_dat = 8'hC0; tb_drv = 1'b1;
      end else begin
        bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
      end
      @(negedge CLK);
      hist[i] = (led_out != 16'h0000);
    end
    bus_we = 1'b0; tb_drv = 1'b0; bus_addr = 8'h00;
    check("mid_p0_count", ones(0, 256), 64);
    check("mid_p0_last", {31'd0, hist[63]}, 32'd1);
    check("mid_p0_end", {31'd0, hist[64]}, 32'd0);
    check("mid_p1_count", ones(256, 256), 8);
    check("mid_p1_end", {31'd0, hist[264]}, 32'd0);
    check("wrap_p2_count", ones(512, 256), 8);
    check("wrap_p3_count", ones(768, 256), 192);
    check("wrap_p3_last", {31'd0, hist[959]}, 32'd1);
    check("wrap_p3_end", {31'd0, hist[960]}, 32'd0);

    // DUTY=00 is always off.
    wr(8'hC2, 8'h00);
    cyc(520);
    collect(256, h, t);
    check("duty00_high", h, 0);

    // DUTY=FF is always on.
    wr(8'hC2, 8'hFF);
    cyc(520);
    collect(64, h, t);
    check("dutyff_high", h, 64);

    // LED_IN to LED_OUT: one cycle.
    led_in = 16'h3C3C;
    #1 check("ledin_same", led_out, 16'hA5A5);
    @(negedge CLK);
    check("ledin_next", led_out, 16'h3C3C);
    led_in = 16'hA5A5;
    @(negedge CLK);

    // CTRL write reaches LED_OUT after two edges.
    wr(8'hC3, 8'h00);
    check("ctrl_lat1", led_out, 16'hA5A5);
    @(negedge CLK);
    check("ctrl_lat2", led_out, 16'h0000);
    wr(8'hC3, 8'h80);
    cyc(2);
    check("ctrl_restore", led_out, 16'hA5A5);

    // Blink rate 0 (32-cycle halves) and rate 3 (4-cycle halves).
    wr(8'hC3, 8'h81);
    cyc(4);
    collect(128, h, t);
    check("blink_r0_high", h, 64);
    check("blink_r0_trans", t, 4);
    wr(8'hC3, 8'h87);
    cyc(4);
    collect(128, h, t);
    check("blink_r3_high", h, 64);
    check("blink_r3_trans", t, 32);

    // Read handshake; reserved CTRL bits read 0.
    wr(8'hC3, 8'hFF);
    bus_addr = 8'hC3; bus_we = 1'b0;
    #1 check("rd_before", bus_data, 8'hFF);
    @(negedge CLK);
    check("rd_c3", bus_data, rd_ctrl_ff);
    bus_addr = 8'hC1;
    #1 check("rd_hold", bus_data, rd_ctrl_ff);
    @(negedge CLK);
    check("rd_c1_z", bus_data, 8'hFF);
    bus_addr = 8'hC4;
    @(negedge CLK);
    check("rd_c4_z", bus_data, 8'hFF);
    bus_addr = 8'hC3;
    @(negedge CLK);
    check("rd_c3_again", bus_data, rd_ctrl_ff);
    bus_we = 1'b1;
    #1 check("rd_we_z", bus_data, 8'hFF);
    @(negedge CLK);
    bus_we = 1'b0; bus_addr = 8'h00;

    // Reset mid-blink with DUTY=10; writes during reset are ignored.
    wr(8'hC2, 8'h10);
    wr(8'hC3, 8'h81);
    cyc(300);
    bus_addr = 8'hC3; bus_we = 1'b0;
    @(negedge CLK);
    check("pre_rst_rd", bus_data, rd_ctrl_81);
    RESET = 1'b0;
    @(negedge CLK);
    check("mid_rst_led", led_out, 16'h0000);
    check("mid_rst_bus", bus_data, 8'hFF);
    wr(8'hC3, 8'h00);
    wr(8'hC2, 8'h00);
    check("rst_hold_led", led_out, 16'h0000);
    RESET = 1'b1;
    @(negedge CLK);
    hist[0] = (led_out != 16'h0000);
    check("post_rst_led", led_out, 16'hA5A5);
    for (int i = 1; i < 512; i++) begin
      if (i - 1 == 0) begin
        bus_addr = 8'hC2; bus_we = 1'b1; tb_dat = 8'h40; tb_drv = 1'b1;
      end else begin
        bus_addr = 8'h00; bus_we = 1'b0; tb_drv = 1'b0;
      end
      @(negedge CLK);
      hist[i] = (led_out != 16'h0000);
    end
    bus_we = 1'b0; tb_drv = 1'b0;
    check("post_rst_p0", ones(0, 256), 256);
    check("post_rst_p1", ones(256, 256), 64);
    check("post_rst_p1_last", {31'd0, hist[319]}, 32'd1);
    check("post_rst_p1_end", {31'd0, hist[320]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
